mm_stage: RTL

Memory stage of the 5-stage MIPS pipeline. Consumes the EX/MM latch outputs, sequences the data-cache request/`dhit` handshake, and stalls upstream stages while an access is outstanding. Holds loaded data across hazard-unit freezes so a completed access is never re-issued. Owns the MM/WB pipeline register that feeds writeback.

---
 rtl/control_unit_types_pkg.sv | 14 +
 rtl/cpu_types_pkg.sv | 8 +
 rtl/mm_stage_if.sv | 24 ++
 rtl/mm_stage_mmwb_reg.sv | 43 ++++
 rtl/mm_stage.sv | 124 ++++++++++++
 5 files changed

// File: rtl/control_unit_types_pkg.sv
// Control encodings: writeback source select and the memory-stage FSM states.
package control_unit_types_pkg;
  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_NPC = 2'd2
  } memtoreg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mmstate_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Basic datapath widths shared across the pipeline.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;
endpackage

// File: rtl/mm_stage_if.sv
// Data-cache port of the memory stage.
// Handshake: a request (dmemREN or dmemWEN, never both) is held with stable
// dmemaddr/dmemstore until the cache answers with dhit; dhit completes the
// request in that same cycle and dmemload is valid only while dhit is high.
interface mm_stage_if;
  import cpu_types_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mm_stage_mmwb_reg.sv
// MM/WB pipeline latch: loads on enable, takes a bubble on flush or once
// halted, and owns the sticky halt flag.
module mmwb_reg
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     en,
  input  logic     flush,
  input  logic     halt,
  input  logic     reg_wen,
  input  regbits_t rd,
  input  word_t    wdat,
  output logic     wb_RegWEN,
  output regbits_t wb_rd,
  output word_t    wb_wdat,
  output logic     wb_halt
);

  // Latch writeback fields; a write to $0 is suppressed here so WB never sees it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_RegWEN <= 1'b0;
      wb_rd     <= '0;
      wb_wdat   <= '0;
      wb_halt   <= 1'b0;
    end else if (en) begin
      if (flush || wb_halt) begin
        wb_RegWEN <= 1'b0;
        wb_rd     <= '0;
        wb_wdat   <= '0;
      end else begin
        wb_RegWEN <= reg_wen & (|rd);
        wb_rd     <= rd;
        wb_wdat   <= wdat;
      end
      if (halt && !flush) begin
        wb_halt <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_stage.sv
// Memory stage: issues data-cache requests, stalls upstream while an access
// is outstanding, keeps loaded data through hazard freezes, and feeds MM/WB.
module mm_stage
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  memtoreg_t  MemtoReg,
  input  logic       RegWEN,
  input  logic       dRENi,
  input  logic       dWENi,
  input  logic       halt,
  input  regbits_t   rd,
  input  word_t      ALUOut,
  input  word_t      store,
  input  word_t      npc,
  input  logic       hz_stall,
  input  logic       flush,
  mm_stage_if.master dcif,
  output logic       mm_stall,
  output logic       wb_RegWEN,
  output regbits_t   wb_rd,
  output word_t      wb_wdat,
  output logic       wb_halt,
  output mmstate_t   mm_state
);

  mmstate_t state, state_n;
  word_t    ldata;
  word_t    wdat;
  logic     memop;
  logic     ren, wen;
  logic     capture;
  logic     load_en;

  // nRST gates requests so the cache sees them vanish as soon as reset hits.
  assign memop = (dRENi | dWENi) & ~flush & ~wb_halt & nRST;

  // Next state and request generation; a load wins over a store if both are set.
  always_comb begin
    state_n = state;
    ren     = 1'b0;
    wen     = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        ren = dRENi & memop;
        wen = dWENi & ~dRENi & memop;
        if (memop && !dcif.dhit) begin
          state_n = BUSY;
        end else if (memop && dcif.dhit && hz_stall) begin
          state_n = DONE;
          capture = 1'b1;
        end
      end
      BUSY: begin
        ren = dRENi & memop;
        wen = dWENi & ~dRENi & memop;
        if (flush) begin
          state_n = IDLE;
        end else if (dcif.dhit && !hz_stall) begin
          state_n = IDLE;
        end else if (dcif.dhit && hz_stall) begin
          state_n = DONE;
          capture = 1'b1;
        end
      end
      DONE: begin
        if (!hz_stall || flush) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and the held copy of load data used while frozen in DONE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      ldata <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        ldata <= dcif.dmemload;
      end
    end
  end

  // Writeback data select; in DONE the cache has moved on, so use the held copy.
  always_comb begin
    wdat = ALUOut;
    unique case (MemtoReg)
      MTR_MEM: wdat = (state == DONE) ? ldata : dcif.dmemload;
      MTR_NPC: wdat = npc;
      default: wdat = ALUOut;
    endcase
  end

  assign dcif.dmemREN   = ren;
  assign dcif.dmemWEN   = wen;
  assign dcif.dmemaddr  = ALUOut;
  assign dcif.dmemstore = store;
  assign mm_stall       = (ren | wen) & ~dcif.dhit;
  assign load_en        = ~mm_stall & ~hz_stall;
  assign mm_state       = state;

  mmwb_reg u_mmwb (
    .CLK       (CLK),
    .nRST      (nRST),
    .en        (load_en),
    .flush     (flush),
    .halt      (halt),
    .reg_wen   (RegWEN),
    .rd        (rd),
    .wdat      (wdat),
    .wb_RegWEN (wb_RegWEN),
    .wb_rd     (wb_rd),
    .wb_wdat   (wb_wdat),
    .wb_halt   (wb_halt)
  );

endmodule
